// File: rtl/alu_exec_stage.sv
// ============================================================================
// alu_exec_stage
// ----------------------------------------------------------------------------
// Execute/writeback stage for a 16-bit combinational ALU.
//
// The stage accepts one instruction word per valid/ready handshake. Two source
// operands are read from an internal 8x16 register file. The operands and the
// op code go to the external ALU through registers. The ALU output is captured
// one cycle later and written back to the destination register.
//
// A host port can load and inspect registers, so the stage can be exercised
// without a fetch unit.
//
// Instruction word layout:
//     [15:13] op    -> ALU select code
//     [12:10] rd    -> destination register
//     [9:7]   rs1   -> source register for operand A
//     [6:4]   rs2   -> source register for operand B
//     [3:0]   ignored
//
// Ports:
//     clk           single clock; all state updates on the rising edge
//     reset         synchronous, active-high reset
//     instr_valid   instr_word is presented
//     instr_ready   stage can accept an instruction this cycle
//     instr_word    instruction word (layout above)
//     alu_a         registered operand A to the ALU
//     alu_b         registered operand B to the ALU
//     alu_sel       registered op code to the ALU (3'b101 = clear after reset)
//     alu_result    combinational ALU output
//     done          one-cycle pulse during the writeback cycle
//     host_wr_en    host register write (IDLE only, has priority over accept)
//     host_wr_addr  host write index
//     host_wr_data  host write data
//     host_rd_addr  host read index
//     host_rd_data  combinational read of regfile[host_rd_addr]
//
// Optional feature (macro ALU_EXEC_FLAGS_EN):
//     Defining this macro adds the flag_z and flag_n outputs.
//     Both flags are registered in the writeback cycle from the written value.
//     Both reset to 0 and hold their value until the next writeback.
//     Leaving the macro undefined removes the ports and the logic.
// ============================================================================
module alu_exec_stage #(
    parameter int NREGS = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr_word,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    output logic             done,
    input  logic             host_wr_en,
    input  logic [2:0]       host_wr_addr,
    input  logic [WIDTH-1:0] host_wr_data,
    input  logic [2:0]       host_rd_addr,
    output logic [WIDTH-1:0] host_rd_data
`ifdef ALU_EXEC_FLAGS_EN
    ,
    output logic             flag_z,
    output logic             flag_n
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    // ALU select code driven out of reset: the ALU's "clear" operation.
    localparam logic [2:0] SEL_CLEAR = 3'b101;

    logic [1:0]       state;
    logic [1:0]       state_next;

    logic [WIDTH-1:0] regs [NREGS];

    logic [2:0]       dest;
    logic [WIDTH-1:0] result;

    logic [2:0]       dec_op;
    logic [2:0]       dec_rd;
    logic [2:0]       dec_rs1;
    logic [2:0]       dec_rs2;
    logic             unused_instr_bits;

    logic             accept;
    logic             host_write_ok;

    // Field decode of the incoming instruction word.
    // The low nibble carries no information. It is folded into a named
    // sink so that it is clearly deliberate.
    assign dec_op            = instr_word[15:13];
    assign dec_rd            = instr_word[12:10];
    assign dec_rs1           = instr_word[9:7];
    assign dec_rs2           = instr_word[6:4];
    assign unused_instr_bits = ^instr_word[3:0];

    // The host port has priority over instruction accept.
    // A host write in IDLE stalls the handshake for that cycle.
    assign instr_ready   = (state == ST_IDLE) && !host_wr_en;
    assign accept        = instr_valid && instr_ready;

    // Host writes outside IDLE are dropped. They are not stalled or queued.
    assign host_write_ok = host_wr_en && (state == ST_IDLE);

    assign done          = (state == ST_WB);

    assign host_rd_data  = regs[host_rd_addr];

    // Three-state sequence: IDLE -> EXEC -> WB -> IDLE.
    // EXEC gives the external ALU a full cycle to settle on the registered
    // operands. WB commits the captured result.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: state_next = ST_WB;
            ST_WB:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operands are read from the register file as it stands at the accept
    // edge. This makes rd == rs1/rs2 use the old value. A dependent
    // instruction issued next always sees the previous writeback, because
    // WB finishes before IDLE can accept again.
    // Outside an accept these registers hold, so the ALU inputs stay stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= SEL_CLEAR;
            dest    <= '0;
        end else if (accept) begin
            alu_a   <= regs[dec_rs1];
            alu_b   <= regs[dec_rs2];
            alu_sel <= dec_op;
            dest    <= dec_rd;
        end
    end

    // Capture the ALU output at the end of EXEC.
    // Writeback then uses a registered value, not the live combinational path.
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
        end else if (state == ST_EXEC) begin
            result <= alu_result;
        end
    end

    // Register file.
    // A writeback and a host write can never collide: one only happens in
    // WB, the other only in IDLE.
    // Reset takes precedence, so an operation in flight is dropped without
    // writing.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (state == ST_WB) begin
            regs[dest] <= result;
        end else if (host_write_ok) begin
            regs[host_wr_addr] <= host_wr_data;
        end
    end

`ifdef ALU_EXEC_FLAGS_EN
    // Status flags describe the most recent writeback.
    // Host writes do not touch them.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (state == ST_WB) begin
            flag_z <= (result == '0);
            flag_n <= result[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// ============================================================================
// tb_alu_exec_stage
// ----------------------------------------------------------------------------
// Self-checking bench for alu_exec_stage.
//
// The bench plays the external combinational ALU:
//     000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT A, 101 CLEAR, 11x MOVE A.
//
// A behavioural model follows the architectural effect of each accepted
// instruction:
//     - the operands latched at accept;
//     - a result committed two cycles later;
//     - host writes applied only while the stage is free.
// A compare process checks the DUT against the model on every falling edge.
// Directed sequences add hand-computed literal expectations.
// ============================================================================
module tb_alu_exec_stage;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_word;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_sel;
    logic [15:0] alu_result;
    logic        done;
    logic        host_wr_en;
    logic [2:0]  host_wr_addr;
    logic [15:0] host_wr_data;
    logic [2:0]  host_rd_addr;
    logic [15:0] host_rd_data;
`ifdef ALU_EXEC_FLAGS_EN
    logic        flag_z;
    logic        flag_n;
`endif

    int checks = 0;
    int errors = 0;

    alu_exec_stage dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_word   (instr_word),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_sel      (alu_sel),
        .alu_result   (alu_result),
        .done         (done),
        .host_wr_en   (host_wr_en),
        .host_wr_addr (host_wr_addr),
        .host_wr_data (host_wr_data),
        .host_rd_addr (host_rd_addr),
        .host_rd_data (host_rd_data)
`ifdef ALU_EXEC_FLAGS_EN
        ,
        .flag_z       (flag_z),
        .flag_n       (flag_n)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [2:0] sel);
        case (sel)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return ~a;
            3'd5:    return 16'h0000;
            default: return a;
        endcase
    endfunction

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 4'b0000};
    endfunction

    // External ALU stand-in.
    assign alu_result = alu_fn(alu_a, alu_b, alu_sel);

    // ---------------- behavioural model ----------------
    logic [15:0] m_regs [8];
    int          m_busy = 0;
    logic [15:0] m_a = '0;
    logic [15:0] m_b = '0;
    logic [2:0]  m_sel = 3'b101;
    logic [2:0]  m_dest = '0;
    logic [15:0] m_res = '0;
    logic        m_z = 1'b0;
    logic        m_n = 1'b0;
    logic        m_on = 1'b0;

    // m_busy counts the cycles left until the stage can accept again.
    // 2 means the ALU cycle, 1 means the writeback cycle.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) m_regs[i] = '0;
            m_busy = 0;
            m_a    = '0;
            m_b    = '0;
            m_sel  = 3'b101;
            m_z    = 1'b0;
            m_n    = 1'b0;
            m_on   = 1'b1;
        end else if (m_on) begin
            if (m_busy == 2) begin
                m_busy = 1;
            end else if (m_busy == 1) begin
                m_regs[m_dest] = m_res;
                m_z    = (m_res == 16'h0000);
                m_n    = m_res[15];
                m_busy = 0;
            end else if (host_wr_en) begin
                m_regs[host_wr_addr] = host_wr_data;
            end else if (instr_valid) begin
                m_a    = m_regs[instr_word[9:7]];
                m_b    = m_regs[instr_word[6:4]];
                m_sel  = instr_word[15:13];
                m_dest = instr_word[12:10];
                m_res  = alu_fn(m_a, m_b, m_sel);
                m_busy = 2;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (m_on) begin
            checkOutput("cmp_instr_ready", {15'b0, instr_ready},
                        {15'b0, (m_busy == 0) && !host_wr_en});
            checkOutput("cmp_done", {15'b0, done}, {15'b0, m_busy == 1});
            checkOutput("cmp_alu_a", alu_a, m_a);
            checkOutput("cmp_alu_b", alu_b, m_b);
            checkOutput("cmp_alu_sel", {13'b0, alu_sel}, {13'b0, m_sel});
            checkOutput("cmp_host_rd", host_rd_data, m_regs[host_rd_addr]);
`ifdef ALU_EXEC_FLAGS_EN
            checkOutput("cmp_flag_z", {15'b0, flag_z}, {15'b0, m_z});
            checkOutput("cmp_flag_n", {15'b0, flag_n}, {15'b0, m_n});
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic v, input logic [15:0] w,
                                 input logic hwe, input logic [2:0] ha,
                                 input logic [15:0] hd);
        tick();
        reset        = rst;
        instr_valid  = v;
        instr_word   = w;
        host_wr_en   = hwe;
        host_wr_addr = ha;
        host_wr_data = hd;
    endtask

    task automatic readReg(input string name, input logic [2:0] a, input logic [15:0] exp_val);
        host_rd_addr = a;
        #1;
        checkOutput(name, host_rd_data, exp_val);
    endtask

    task automatic hostWrite(input logic [2:0] a, input logic [15:0] d);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, a, d);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0);
    endtask

    // Issue one instruction and follow it through EXEC (cycle 1), WB (cycle 2)
    // and readback (cycle 3).
    task automatic issue(input string tag, input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic [15:0] exp_a, input logic [15:0] exp_b,
                         input logic [15:0] exp_val);
        applyStimulus(1'b0, 1'b1, mk(op, rd, rs1, rs2), 1'b0, 3'd0, 16'h0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0);
        checkOutput({tag, "_alu_a"}, alu_a, exp_a);
        checkOutput({tag, "_alu_b"}, alu_b, exp_b);
        checkOutput({tag, "_alu_sel"}, {13'b0, alu_sel}, {13'b0, op});
        checkOutput({tag, "_ready_exec"}, {15'b0, instr_ready}, 16'h0);
        checkOutput({tag, "_done_exec"}, {15'b0, done}, 16'h0);
        tick();
        checkOutput({tag, "_done_wb"}, {15'b0, done}, 16'h1);
        tick();
        checkOutput({tag, "_done_after"}, {15'b0, done}, 16'h0);
        readReg({tag, "_rd"}, rd, exp_val);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic expected_ready [6];
        expected_ready = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        reset        = 1'b1;
        instr_valid  = 1'b0;
        instr_word   = 16'h0;
        host_wr_en   = 1'b0;
        host_wr_addr = 3'd0;
        host_wr_data = 16'h0;
        host_rd_addr = 3'd0;

        // Reset state
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0);
        checkOutput("rst_ready", {15'b0, instr_ready}, 16'h1);
        checkOutput("rst_alu_sel", {13'b0, alu_sel}, 16'h0005);
        checkOutput("rst_done", {15'b0, done}, 16'h0);
        for (int i = 0; i < 8; i++) begin
            readReg("rst_reg", i[2:0], 16'h0000);
            tick();
        end

        // ADD r3 = r1 + r2
        hostWrite(3'd1, 16'h0005);
        hostWrite(3'd2, 16'h0003);
        issue("add", 3'd0, 3'd3, 3'd1, 3'd2, 16'h0005, 16'h0003, 16'h0008);
        checkOutput("model_pin_r3", m_regs[3], 16'h0008);

        // SUB wraps; then CLEAR
        hostWrite(3'd1, 16'h0000);
        hostWrite(3'd2, 16'h0001);
        issue("sub", 3'd1, 3'd4, 3'd1, 3'd2, 16'h0000, 16'h0001, 16'hFFFF);
`ifdef ALU_EXEC_FLAGS_EN
        checkOutput("sub_flag_n", {15'b0, flag_n}, 16'h1);
        checkOutput("sub_flag_z", {15'b0, flag_z}, 16'h0);
`endif
        issue("clr", 3'd5, 3'd4, 3'd4, 3'd4, 16'hFFFF, 16'hFFFF, 16'h0000);
`ifdef ALU_EXEC_FLAGS_EN
        checkOutput("clr_flag_z", {15'b0, flag_z}, 16'h1);
        checkOutput("clr_flag_n", {15'b0, flag_n}, 16'h0);
`endif

        // Back-to-back ADD r1, r1, r1 with instr_valid held high
        hostWrite(3'd1, 16'h0002);
        host_rd_addr = 3'd1;
        applyStimulus(1'b0, 1'b1, mk(3'd0, 3'd1, 3'd1, 3'd1), 1'b0, 3'd0, 16'h0);
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput("b2b_ready", {15'b0, instr_ready}, {15'b0, expected_ready[k]});
            if (k == 2) checkOutput("b2b_r1_first", host_rd_data, 16'h0004);
            if (k == 5) checkOutput("b2b_r1_second", host_rd_data, 16'h0008);
        end
        instr_valid = 1'b0;
        checkOutput("model_pin_r1", m_regs[1], 16'h0008);

        // Host write has priority over a simultaneous instruction
        applyStimulus(1'b0, 1'b1, mk(3'd0, 3'd7, 3'd1, 3'd1), 1'b1, 3'd5, 16'h1234);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0);
        #1;
        checkOutput("prio_ready", {15'b0, instr_ready}, 16'h1);
        readReg("prio_r5", 3'd5, 16'h1234);
        tick();
        checkOutput("prio_no_done", {15'b0, done}, 16'h0);
        readReg("prio_r7", 3'd7, 16'h0000);

        // Host write during EXEC is dropped
        applyStimulus(1'b0, 1'b1, mk(3'd0, 3'd7, 3'd1, 3'd1), 1'b0, 3'd0, 16'h0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 3'd5, 16'hBEEF);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0);
        checkOutput("exec_hw_done", {15'b0, done}, 16'h1);
        tick();
        readReg("exec_hw_r5", 3'd5, 16'h1234);
        readReg("exec_hw_r7", 3'd7, 16'h0010);

        // NOT r6, r1 aborted by reset during EXEC
        applyStimulus(1'b0, 1'b1, mk(3'd4, 3'd6, 3'd1, 3'd0), 1'b0, 3'd0, 16'h0);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0);
        checkOutput("abort_alu_sel_exec", {13'b0, alu_sel}, 16'h0004);
        checkOutput("abort_done_exec", {15'b0, done}, 16'h0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0);
        checkOutput("abort_ready", {15'b0, instr_ready}, 16'h1);
        checkOutput("abort_alu_sel", {13'b0, alu_sel}, 16'h0005);
        checkOutput("abort_done0", {15'b0, done}, 16'h0);
        readReg("abort_r6", 3'd6, 16'h0000);
        tick();
        checkOutput("abort_done1", {15'b0, done}, 16'h0);
        tick();
        checkOutput("abort_done2", {15'b0, done}, 16'h0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
